// File: rtl/logic_pkg.sv
// Shared constants for the logic-unit issue front end: ctrl encodings,
// MIPS opcode/funct values and the issue FSM state type.
package logic_pkg;

    localparam logic [3:0] LU_AND   = 4'b1000;
    localparam logic [3:0] LU_OR    = 4'b1110;
    localparam logic [3:0] LU_XOR   = 4'b0110;
    localparam logic [3:0] LU_NOR   = 4'b0001;
    localparam logic [3:0] LU_PASSA = 4'b1010;
    localparam logic [3:0] LU_NOP   = 4'b0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/logic_op_decode.sv
// Combinational decode of opcode/funct/imm into logic-unit ctrl and operands.
// LUI is decoded only when LOGIC_ISSUE_LUI_EN is defined.
module logic_op_decode
    import logic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [15:0]      imm,
    output logic [3:0]       dec_ctrl,
    output logic [WIDTH-1:0] dec_a,
    output logic [WIDTH-1:0] dec_b,
    output logic             dec_illegal
);

    logic [WIDTH-1:0] w_imm_zext;
    assign w_imm_zext = {{(WIDTH-16){1'b0}}, imm};

    always_comb begin
        dec_ctrl    = LU_NOP;
        dec_a       = '0;
        dec_b       = '0;
        dec_illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec_a = rs_val;
                dec_b = rt_val;
                case (funct)
                    FN_AND:  dec_ctrl = LU_AND;
                    FN_OR:   dec_ctrl = LU_OR;
                    FN_XOR:  dec_ctrl = LU_XOR;
                    FN_NOR:  dec_ctrl = LU_NOR;
                    default: begin
                        dec_a       = '0;
                        dec_b       = '0;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            OP_ANDI: begin
                dec_ctrl = LU_AND;
                dec_a    = rs_val;
                dec_b    = w_imm_zext;
            end
            OP_ORI: begin
                dec_ctrl = LU_OR;
                dec_a    = rs_val;
                dec_b    = w_imm_zext;
            end
            OP_XORI: begin
                dec_ctrl = LU_XOR;
                dec_a    = rs_val;
                dec_b    = w_imm_zext;
            end
`ifdef LOGIC_ISSUE_LUI_EN
            // LUI rides the pass-A path so the logic unit returns imm<<16 unchanged.
            OP_LUI: begin
                dec_ctrl = LU_PASSA;
                dec_a    = {imm, {(WIDTH-16){1'b0}}};
            end
`else
            OP_LUI: dec_illegal = 1'b1;
`endif
            default: dec_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/logic_issue_ctrl.sv
// Issue front end for the 32-bit logic unit: decode, registered drive, result capture.
// Build option: LOGIC_ISSUE_LUI_EN enables LUI decode (handled in logic_op_decode).
module logic_issue_ctrl
    import logic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [15:0]      imm,
    output logic [3:0]       lu_ctrl,
    output logic [WIDTH-1:0] lu_a,
    output logic [WIDTH-1:0] lu_b,
    input  logic [WIDTH-1:0] lu_dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_illegal,
    output logic [CNT_W-1:0] op_count
);

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_lu_ctrl;
    logic [WIDTH-1:0] r_lu_a;
    logic [WIDTH-1:0] r_lu_b;
    logic             r_lu_illegal;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_illegal;
    logic [CNT_W-1:0] r_op_count;

    logic [3:0]       w_dec_ctrl;
    logic [WIDTH-1:0] w_dec_a;
    logic [WIDTH-1:0] w_dec_b;
    logic             w_dec_illegal;

    logic_op_decode #(.WIDTH(WIDTH)) u_decode (
        .opcode      (opcode),
        .funct       (funct),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .imm         (imm),
        .dec_ctrl    (w_dec_ctrl),
        .dec_a       (w_dec_a),
        .dec_b       (w_dec_b),
        .dec_illegal (w_dec_illegal)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = EXEC;
            EXEC:    w_state_next = RESP;
            RESP:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_lu_ctrl     <= LU_NOP;
            r_lu_a        <= '0;
            r_lu_b        <= '0;
            r_lu_illegal  <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_illegal <= 1'b0;
            r_op_count    <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_lu_ctrl    <= w_dec_ctrl;
                        r_lu_a       <= w_dec_a;
                        r_lu_b       <= w_dec_b;
                        r_lu_illegal <= w_dec_illegal;
                    end
                end
                EXEC: begin
                    r_out_data    <= lu_dout;
                    r_out_illegal <= r_lu_illegal;
                    r_out_valid   <= 1'b1;
                end
                RESP: begin
                    // Count only on the consumer handshake so a stalled result is counted once.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (!r_out_illegal && (r_op_count != {CNT_W{1'b1}}))
                            r_op_count <= r_op_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign lu_ctrl     = r_lu_ctrl;
    assign lu_a        = r_lu_a;
    assign lu_b        = r_lu_b;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_illegal = r_out_illegal;
    assign op_count    = r_op_count;

endmodule

// File: tb/tb_logic_issue_ctrl.sv
// Self-checking bench for logic_issue_ctrl with a behavioural logic unit and a result scoreboard.
// A second instance with a 2-bit counter exercises counter saturation.
module tb_logic_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [15:0] imm;
    logic [3:0]  lu_ctrl;
    logic [31:0] lu_a;
    logic [31:0] lu_b;
    logic [31:0] lu_dout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_illegal;
    logic [15:0] op_count;

    logic        s_in_ready;
    logic [3:0]  s_lu_ctrl;
    logic [31:0] s_lu_a;
    logic [31:0] s_lu_b;
    logic [31:0] s_lu_dout;
    logic        s_out_valid;
    logic [31:0] s_out_data;
    logic        s_out_illegal;
    logic [1:0]  s_op_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_count;
    logic [32:0] sb_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] lu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b1000: return a & b;
            4'b1110: return a | b;
            4'b0110: return a ^ b;
            4'b0001: return ~(a | b);
            4'b1010: return a;
            default: return 32'h0;
        endcase
    endfunction

    assign lu_dout   = lu_model(lu_ctrl, lu_a, lu_b);
    assign s_lu_dout = lu_model(s_lu_ctrl, s_lu_a, s_lu_b);

    logic_issue_ctrl #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .rs_val(rs_val), .rt_val(rt_val), .imm(imm),
        .lu_ctrl(lu_ctrl), .lu_a(lu_a), .lu_b(lu_b), .lu_dout(lu_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_illegal(out_illegal), .op_count(op_count)
    );

    logic_issue_ctrl #(.WIDTH(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .opcode(opcode), .funct(funct), .rs_val(rs_val), .rt_val(rt_val), .imm(imm),
        .lu_ctrl(s_lu_ctrl), .lu_a(s_lu_a), .lu_b(s_lu_b), .lu_dout(s_lu_dout),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_illegal(s_out_illegal), .op_count(s_op_count)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one request, wait for acceptance, check the registered drive to the logic unit.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [15:0] im, input logic [31:0] exp_data,
                         input logic exp_ill, input logic [3:0] exp_ctrl, input logic [31:0] exp_b);
        int cyc = 0;
        opcode = op; funct = fn; rs_val = rs; rt_val = rt; imm = im;
        in_valid = 1'b1;
        while (!in_ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL issue_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb_q.push_back({exp_ill, exp_data});
        if (!exp_ill) exp_count++;
        n_checks++;
        if (lu_ctrl !== exp_ctrl) begin
            n_fail++;
            $display("FAIL lu_ctrl: got %b required %b", lu_ctrl, exp_ctrl);
        end
        n_checks++;
        if (lu_b !== exp_b) begin
            n_fail++;
            $display("FAIL lu_b: got %h required %h", lu_b, exp_b);
        end
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL exec_state: out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
        end
    endtask

    // Wait for a result, compare against the scoreboard head, complete the handshake.
    task automatic collect(output int lat);
        logic [32:0] exp;
        int cyc = 0;
        out_ready = 1'b1;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        lat = cyc;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 33'h0;
        n_checks++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL collect_timeout: out_valid=%b required 1", out_valid);
        end
        n_checks++;
        if (out_data !== exp[31:0] || out_illegal !== exp[32]) begin
            n_fail++;
            $display("FAIL result: data=%h illegal=%b required data=%h illegal=%b",
                     out_data, out_illegal, exp[31:0], exp[32]);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        n_checks++;
        if (op_count !== 16'(exp_count)) begin
            n_fail++;
            $display("FAIL op_count: got %0d required %0d", op_count, exp_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; funct = '0; rs_val = '0; rt_val = '0; imm = '0;
        repeat (3) @(posedge clk);
        #1;
        exp_count = 0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_illegal !== 1'b0 || op_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_ctl: in_ready=%b out_valid=%b out_illegal=%b op_count=%h required 1 0 0 0",
                     in_ready, out_valid, out_illegal, op_count);
        end
        n_checks++;
        if (lu_ctrl !== 4'b0 || lu_a !== 32'h0 || lu_b !== 32'h0 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: lu_ctrl=%b lu_a=%h lu_b=%h out_data=%h required all 0",
                     lu_ctrl, lu_a, lu_b, out_data);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_and();
        int lat;
        issue(6'h00, 6'h24, 32'hF0F0_1234, 32'h0FF0_FFFF, 16'h0, 32'h00F0_1234, 1'b0, 4'b1000, 32'h0FF0_FFFF);
        n_checks++;
        if (lu_a !== 32'hF0F0_1234) begin
            n_fail++;
            $display("FAIL and_lu_a: got %h required F0F01234", lu_a);
        end
        collect(lat);
        n_checks++;
        if (lat != 1) begin
            n_fail++;
            $display("FAIL and_latency: got %0d cycles required 1", lat);
        end
    endtask

    task automatic test_nor_ori();
        int lat;
        issue(6'h00, 6'h27, 32'h0, 32'h0000_00FF, 16'h0, 32'hFFFF_FF00, 1'b0, 4'b0001, 32'h0000_00FF);
        collect(lat);
        issue(6'h0D, 6'h3F, 32'h1234_0000, 32'hDEAD_BEEF, 16'hABCD, 32'h1234_ABCD, 1'b0, 4'b1110, 32'h0000_ABCD);
        collect(lat);
        issue(6'h00, 6'h25, 32'hA000_0005, 32'h0A00_0050, 16'h0, 32'hAA00_0055, 1'b0, 4'b1110, 32'h0A00_0050);
        collect(lat);
        issue(6'h0C, 6'h00, 32'hFFFF_FFFF, 32'h0, 16'h8421, 32'h0000_8421, 1'b0, 4'b1000, 32'h0000_8421);
        collect(lat);
        issue(6'h0E, 6'h00, 32'h5555_5555, 32'h0, 16'hFFFF, 32'h5555_AAAA, 1'b0, 4'b0110, 32'h0000_FFFF);
        collect(lat);
    endtask

    task automatic test_illegal();
        int lat;
        issue(6'h08, 6'h24, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h1234, 32'h0, 1'b1, 4'b0000, 32'h0);
        n_checks++;
        if (lu_a !== 32'h0) begin
            n_fail++;
            $display("FAIL illegal_lu_a: got %h required 0", lu_a);
        end
        collect(lat);
        issue(6'h00, 6'h20, 32'hFFFF_FFFF, 32'h1, 16'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
        collect(lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [32:0] exp_a;
        issue(6'h00, 6'h26, 32'hFFFF_0000, 32'h0F0F_0F0F, 16'h0, 32'hF0F0_0F0F, 1'b0, 4'b0110, 32'h0F0F_0F0F);
        opcode = 6'h00; funct = 6'h26; rs_val = 32'h1234_5678; rt_val = 32'hFFFF_FFFF; imm = 16'h0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        exp_a = (sb_q.size() > 0) ? sb_q[0] : 33'h0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== exp_a[31:0]) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: in_ready=%b out_valid=%b data=%h required 0 1 %h",
                         i, in_ready, out_valid, out_data, exp_a[31:0]);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        collect(lat);
        n_checks++;
        if (lu_a !== 32'hFFFF_0000) begin
            n_fail++;
            $display("FAIL second_early: lu_a=%h required FFFF0000 (second request not yet taken)", lu_a);
        end
        issue(6'h00, 6'h26, 32'h1234_5678, 32'hFFFF_FFFF, 16'h0, 32'hEDCB_A987, 1'b0, 4'b0110, 32'hFFFF_FFFF);
        collect(lat);
    endtask

    task automatic test_lui();
        int lat;
`ifdef LOGIC_ISSUE_LUI_EN
        issue(6'h0F, 6'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h8001, 32'h8001_0000, 1'b0, 4'b1010, 32'h0);
`else
        issue(6'h0F, 6'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h8001, 32'h0, 1'b1, 4'b0000, 32'h0);
`endif
        collect(lat);
    endtask

    task automatic test_reset_mid_exec();
        issue(6'h00, 6'h24, 32'hFFFF_FFFF, 32'h1234_5678, 16'h0, 32'h1234_5678, 1'b0, 4'b1000, 32'h1234_5678);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_q.delete();
        exp_count = 0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || op_count !== 16'h0 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_exec: in_ready=%b out_valid=%b op_count=%h out_data=%h required 1 0 0 0",
                     in_ready, out_valid, op_count, out_data);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drop: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_saturate();
        int lat;
        for (int i = 0; i < 5; i++) begin
            issue(6'h0D, 6'h00, 32'h0, 32'h0, 16'(i), 32'(i), 1'b0, 4'b1110, 32'(i));
            collect(lat);
            n_checks++;
            if (s_op_count !== ((i + 1 >= 3) ? 2'd3 : 2'(i + 1))) begin
                n_fail++;
                $display("FAIL saturate[%0d]: op_count=%0d required %0d", i, s_op_count,
                         (i + 1 >= 3) ? 3 : i + 1);
            end
        end
        issue(6'h08, 6'h00, 32'h0, 32'h0, 16'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
        collect(lat);
        n_checks++;
        if (s_op_count !== 2'd3) begin
            n_fail++;
            $display("FAIL saturate_hold: op_count=%0d required 3", s_op_count);
        end
    endtask

    initial begin
        test_reset();
        test_and();
        test_nor_ori();
        test_illegal();
        test_back_to_back();
        test_lui();
        test_reset_mid_exec();
        test_saturate();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_issue_ctrl.md
Name: logic_issue_ctrl

Overview:
- Sequential front end for the CPU's 32-bit logic unit.
- Accepts decoded-instruction fields over a valid/ready handshake and maps them to the logic unit's 4-bit ctrl encoding.
- Forms the A/B operands, including immediate zero-extension and LUI shifting.
- Drives the logic unit registered, captures its result, and returns it over a second valid/ready handshake.
- Sits between the ID/EX stage and the logic unit; it is the producer of the ctrl codes the logic unit consumes.

Parameters:
- WIDTH, 32, datapath width (fixed at 32 for MIPS; the immediate rules assume 32).
- CNT_W, 16, width of the saturating issued-operation counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- opcode  input  6  instruction opcode field.
- funct  input  6  instruction funct field (used when opcode==6'h00).
- rs_val  input  WIDTH  rs register value.
- rt_val  input  WIDTH  rt register value.
- imm  input  16  immediate field.
- lu_ctrl  output  4  ctrl to logic unit.
- lu_a  output  WIDTH  operand A to logic unit.
- lu_b  output  WIDTH  operand B to logic unit.
- lu_dout  input  WIDTH  combinational result from logic unit.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  captured result.
- out_illegal  output  1  request did not decode to a logic op.
- op_count  output  CNT_W  number of legal ops completed, saturating.

Behaviour:
- Reset (rst_n==0 at a clock edge):
  - state=IDLE.
  - lu_ctrl=4'b0000; lu_a, lu_b, out_data = 0.
  - out_valid=0, out_illegal=0, op_count=0.
  - Reset overrides everything, including mid-EXEC and mid-RESP; any pending result is dropped.
- Decode (combinational on inputs, registered on accept):
  - opcode 00, funct 24 (AND): ctrl=1000, A=rs, B=rt.
  - opcode 00, funct 25 (OR): ctrl=1110, A=rs, B=rt.
  - opcode 00, funct 26 (XOR): ctrl=0110, A=rs, B=rt.
  - opcode 00, funct 27 (NOR): ctrl=0001, A=rs, B=rt.
  - opcode 0C (ANDI): ctrl=1000, A=rs, B={16'h0,imm}.
  - opcode 0D (ORI): ctrl=1110, A=rs, B={16'h0,imm}.
  - opcode 0E (XORI): ctrl=0110, A=rs, B={16'h0,imm}.
  - opcode 0F (LUI): see Optional Feature.
  - Anything else is illegal: ctrl=0000, A=0, B=0, illegal flag=1.
- FSM:
  - IDLE: in_ready=1. On in_valid, register the decoded ctrl/A/B/illegal into the lu_* regs, go to EXEC.
  - EXEC: in_ready=0; lu_* stable. At the edge, capture out_data=lu_dout and out_illegal=illegal flag, set out_valid=1, go to RESP.
  - RESP: in_ready=0; out_valid, out_data and out_illegal held stable. On out_ready, clear out_valid. Increment op_count when not illegal, saturating at all-ones. Go to IDLE.
  - Simultaneous out_ready and a new in_valid in RESP: the request is not accepted (in_ready=0); it is taken in the following IDLE cycle.
- Latency and throughput:
  - Accept at edge N, out_valid high after edge N+1.
  - Minimum initiation interval is 3 cycles with out_ready held at 1.
- Illegal requests still complete the handshake with out_data=0 (the logic unit returns 0 for ctrl 0000), out_illegal=1, and op_count unchanged.
- lu_* hold their last values outside EXEC; the consumer must not rely on them.

Optional Feature:
- Macro: LOGIC_ISSUE_LUI_EN.
- Defined: opcode 0F decodes to ctrl=1010 (pass A) with A={imm,16'h0} and B=0; result is imm<<16.
- Undefined: opcode 0F is illegal (out_illegal=1, out_data=0).

Decomposition:
- Shared package logic_pkg holds:
  - the ctrl encodings LU_AND=1000, LU_OR=1110, LU_XOR=0110, LU_NOR=0001, LU_PASSA=1010, LU_NOP=0000;
  - the opcode/funct constants;
  - the FSM state enum (IDLE, EXEC, RESP).
- One natural sub-module: logic_op_decode, purely combinational (opcode, funct, rs, rt, imm to ctrl, A, B, illegal). The FSM and registers stay in the top.

Test Plan:
- Reset, then AND: rs=F0F0_1234, rt=0FF0_FFFF -> lu_ctrl=1000; out_data=00F0_1234 two edges after accept; out_illegal=0; op_count=1.
- NOR: rs=0, rt=0000_00FF -> out_data=FFFF_FF00. ORI: rs=1234_0000, imm=ABCD -> lu_b=0000_ABCD, out_data=1234_ABCD.
- Illegal opcode 08 -> out_illegal=1, out_data=0, op_count unchanged, lu_ctrl=0000.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and a new XOR request -> out_data stable, in_ready=0 throughout; second request accepted only after the out_ready handshake.
- LUI imm=8001 -> out_data=8001_0000 with LOGIC_ISSUE_LUI_EN defined; out_illegal=1 and out_data=0 without it.
- Assert rst_n=0 during EXEC -> next cycle state IDLE, out_valid=0, op_count=0. Separately, force op_count to all-ones, complete an op -> op_count stays FFFF.
